// File: rtl/keccak_squeezer.sv
// Streams the permuted Keccak state out as 64-bit words, requesting extra permutations for long outputs.
// Optional SQZ_BYTE_SWAP_EN: byte-reverse each lane (FIPS-202 byte-stream order); default emits lanes unchanged.
module keccak_squeezer #(
  parameter int LEN_W        = 16,
  parameter int PERM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic [1:0]       i_mode,
  input  logic [LEN_W-1:0] i_len_words,
  input  logic [1599:0]    i_state_in,
  input  logic             i_state_ready,
  input  logic             i_perm_calc,
  output logic             o_squeeze,
  output logic             o_pack,
  output logic [63:0]      o_dout,
  output logic             o_dout_valid,
  input  logic             i_dout_ready,
  output logic             o_dout_last,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  localparam int TMO_W = $clog2(PERM_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_STATE, S_EMIT, S_REQ, S_WAIT_PERM, S_FIN
  } state_t;

  state_t           r_state;
  logic [1599:0]    r_buf;
  logic [4:0]       r_lanes;
  logic [4:0]       r_lane_idx;
  logic [LEN_W-1:0] r_rem;
  logic [TMO_W-1:0] r_tmo;
  logic             r_perm_seen;
  logic [63:0]      r_dout;
  logic             r_dout_valid;
  logic             r_dout_last;
  logic             r_squeeze;
  logic             r_pack;
  logic             r_busy;
  logic             r_done;
  logic             r_err;

  logic [63:0]      w_lane [25];
  logic [4:0]       w_idx_nxt;
  logic [4:0]       w_lanes_sel;
  logic             w_xfer;
  logic             w_cap;

  function automatic logic [63:0] f_fmt(input logic [63:0] lane);
    logic [63:0] res;
`ifdef SQZ_BYTE_SWAP_EN
    for (int i = 0; i < 8; i++) res[8*i +: 8] = lane[56-8*i +: 8];
`else
    res = lane;
`endif
    return res;
  endfunction

  for (genvar g = 0; g < 25; g++) begin : g_lane
    assign w_lane[g] = r_buf[1599-64*g -: 64];
  end

  assign w_idx_nxt = r_lane_idx + 5'd1;
  assign w_xfer    = r_dout_valid & i_dout_ready;
  assign w_cap     = i_state_ready & ~i_perm_calc &
                     ((r_state == S_WAIT_STATE) || (r_state == S_WAIT_PERM && r_perm_seen));

  always_comb begin
    w_lanes_sel = 5'd17;
    case (i_mode)
      2'd1:    w_lanes_sel = 5'd9;
      2'd2:    w_lanes_sel = 5'd21;
      default: w_lanes_sel = 5'd17;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_lanes      <= '0;
      r_lane_idx   <= '0;
      r_rem        <= '0;
      r_tmo        <= '0;
      r_perm_seen  <= 1'b0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_dout_last  <= 1'b0;
      r_squeeze    <= 1'b0;
      r_pack       <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_squeeze <= 1'b0;
      r_pack    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_err <= 1'b0;
            if (i_len_words == '0) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_lanes <= w_lanes_sel;
              r_rem   <= i_len_words;
              r_busy  <= 1'b1;
              r_state <= S_WAIT_STATE;
            end
          end
        end
        S_WAIT_STATE: ;
        S_EMIT: begin
          if (w_xfer) begin
            if (r_rem != '0) r_rem <= r_rem - LEN_W'(1);
            r_lane_idx <= w_idx_nxt;
            if (r_rem <= LEN_W'(1)) begin
              r_dout_valid <= 1'b0;
              r_dout_last  <= 1'b0;
              r_done       <= 1'b1;
              r_busy       <= 1'b0;
              r_state      <= S_FIN;
            end else if (w_idx_nxt == r_lanes) begin
              r_dout_valid <= 1'b0;
              r_dout_last  <= 1'b0;
              r_squeeze    <= 1'b1;
              r_pack       <= 1'b1;
              r_state      <= S_REQ;
            end else begin
              r_dout      <= f_fmt(w_lane[w_idx_nxt]);
              r_dout_last <= (r_rem == LEN_W'(2));
            end
          end
        end
        S_REQ: begin
          r_tmo       <= '0;
          r_perm_seen <= 1'b0;
          r_state     <= S_WAIT_PERM;
        end
        S_WAIT_PERM: begin
          if (i_perm_calc) r_perm_seen <= 1'b1;
          r_tmo <= r_tmo + TMO_W'(1);
          // Count starts the cycle after REQ, so done lands PERM_TIMEOUT cycles after the squeeze cycle.
          if (!w_cap && r_tmo == TMO_W'(PERM_TIMEOUT-2)) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_cap) begin
        r_buf        <= i_state_in;
        r_lane_idx   <= '0;
        r_dout       <= f_fmt(i_state_in[1599 -: 64]);
        r_dout_valid <= 1'b1;
        r_dout_last  <= (r_rem == LEN_W'(1));
        r_state      <= S_EMIT;
      end
    end
  end

  assign o_squeeze    = r_squeeze;
  assign o_pack       = r_pack;
  assign o_dout       = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_dout_last  = r_dout_last;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule

// File: tb/tb_keccak_squeezer.sv
// Bench for keccak_squeezer: table of sessions against a simple permutation-core model, plus timeout and reset sequences.
module tb_keccak_squeezer;
  localparam int LEN_W = 16;
  localparam int PT    = 64;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [1:0]       mode;
  logic [LEN_W-1:0] len_words;
  logic [1599:0]    state_in;
  logic             state_ready;
  logic             perm_calc;
  logic             squeeze, pack;
  logic [63:0]      dout;
  logic             dout_valid, dout_ready, dout_last;
  logic             busy, done, err;

  always #5 clk = ~clk;

  keccak_squeezer #(.LEN_W(LEN_W), .PERM_TIMEOUT(PT)) dut (
    .clk(clk), .reset(reset), .i_start(start), .i_mode(mode), .i_len_words(len_words),
    .i_state_in(state_in), .i_state_ready(state_ready), .i_perm_calc(perm_calc),
    .o_squeeze(squeeze), .o_pack(pack), .o_dout(dout), .o_dout_valid(dout_valid),
    .i_dout_ready(dout_ready), .o_dout_last(dout_last), .o_busy(busy), .o_done(done), .o_err(err)
  );

  typedef struct { logic [1:0] mode; int len; bit stall; int exp_sq; } vec_t;
  typedef struct { logic [63:0] w; logic last; } exp_t;

  exp_t        q[$];
  int          n_checks = 0, n_pass = 0;
  int          cyc = 0, xfers = 0, sq_cnt = 0, done_cnt = 0;
  int          last_xfer_cyc = 0, sq_cyc = 0, done_cyc = 0;
  int          sess_x0 = 0, cur_lanes = 17, cur_len = 0;
  int          cfg_gen = 0;
  logic [63:0] cfg_base = '0;
  bit          core_hang = 1'b0;
  bit          stall_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] fmt(input logic [63:0] l);
    logic [63:0] r;
`ifdef SQZ_BYTE_SWAP_EN
    for (int i = 0; i < 8; i++) r[8*i +: 8] = l[56-8*i +: 8];
`else
    r = l;
`endif
    return r;
  endfunction

  function automatic int lanes_of(input logic [1:0] m);
    case (m)
      2'd1:    return 9;
      2'd2:    return 21;
      default: return 17;
    endcase
  endfunction

  function automatic logic [1599:0] mk_state(input logic [63:0] base);
    logic [1599:0] s;
    for (int k = 0; k < 25; k++) s[1599-64*k -: 64] = base + 64'(k) + 64'd1;
    return s;
  endfunction

  // Permutation core model: 25-cycle permutation per squeeze, each new state's lane base advanced by 0x100.
  initial begin
    int          seen;
    logic [63:0] cur;
    seen = 0; cur = '0;
    state_in = mk_state('0); state_ready = 1'b1; perm_calc = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cfg_gen != seen) begin
        seen = cfg_gen; cur = cfg_base;
        state_in = mk_state(cur); state_ready = 1'b1; perm_calc = 1'b0;
      end else if (squeeze) begin
        state_ready = 1'b0;
        if (!core_hang) begin
          perm_calc = 1'b1;
          repeat (25) @(posedge clk);
          #1;
          cur = cur + 64'h100;
          state_in = mk_state(cur); perm_calc = 1'b0; state_ready = 1'b1;
        end
      end
    end
  end

  initial begin
    int ph;
    ph = 0; dout_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_en) begin dout_ready = (ph == 0); ph = (ph + 1) % 3; end
      else dout_ready = 1'b1;
    end
  end

  // Monitor / scoreboard consumer
  initial begin
    logic        p_stall, p_last;
    logic [63:0] p_dout;
    exp_t        e;
    p_stall = 1'b0; p_last = 1'b0; p_dout = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) p_stall = 1'b0;
      else begin
        if (p_stall) begin
          chk("stall_valid", dout_valid, 1);
          chk("stall_dout", dout, p_dout);
          chk("stall_last", dout_last, p_last);
        end
        if (dout_valid && dout_ready) begin
          xfers++; last_xfer_cyc = cyc;
          if (q.size() == 0) chk("extra_word", q.size(), 1);
          else begin
            e = q.pop_front();
            chk("word", dout, e.w);
            chk("last", dout_last, e.last);
          end
        end
        if (squeeze) begin
          sq_cnt++; sq_cyc = cyc;
          chk("pack_with_squeeze", pack, 1);
          chk("squeeze_at_block_end", (xfers - sess_x0) % cur_lanes, 0);
          chk("squeeze_before_last", (xfers - sess_x0) < cur_len, 1);
        end
        if (done) begin done_cnt++; done_cyc = cyc; end
        p_stall = dout_valid && !dout_ready;
        p_dout = dout; p_last = dout_last;
      end
    end
  end

  task automatic push_exp(input logic [63:0] base, input int len, input int lanes, input int n);
    for (int k = 0; k < n; k++)
      q.push_back('{fmt(base + 64'((k / lanes) * 256 + (k % lanes) + 1)), k == len - 1});
  endtask

  task automatic begin_session(input logic [1:0] m, input int len, input logic [63:0] base, input int n_exp);
    cfg_base = base; cfg_gen++;
    repeat (2) @(negedge clk);
    cur_lanes = lanes_of(m); cur_len = len; sess_x0 = xfers;
    push_exp(base, len, cur_lanes, n_exp);
    start = 1'b1; mode = m; len_words = LEN_W'(len);
    @(negedge clk);
    start = 1'b0; mode = ~m; len_words = LEN_W'(len + 5);
    chk("err_cleared_on_start", err, 0);
  endtask

  task automatic wait_done(input int d0, input int budget);
    for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clk);
    chk("done_seen", done_cnt != d0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run_session(input logic [1:0] m, input int len, input bit stall, input int exp_sq,
                             input logic [63:0] base);
    int sq0, d0;
    sq0 = sq_cnt; d0 = done_cnt;
    stall_en = stall;
    begin_session(m, len, base, len);
    if (stall) begin
      repeat (4) @(negedge clk);
      start = 1'b1; mode = 2'd2; len_words = 3; @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b1; len_words = 40; @(negedge clk); start = 1'b0;
    end
    wait_done(d0, 2000);
    stall_en = 1'b0;
    chk("xfers", xfers - sess_x0, len);
    chk("squeezes", sq_cnt - sq0, exp_sq);
    chk("done_once", done_cnt - d0, 1);
    chk("queue_empty", q.size(), 0);
    if (len > 0) chk("done_after_last", done_cyc - last_xfer_cyc, 1);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   d0, sq0;
    vecs[0] = '{2'd1, 4,  1'b0, 0};
    vecs[1] = '{2'd1, 12, 1'b0, 1};
    vecs[2] = '{2'd2, 21, 1'b0, 0};
    vecs[3] = '{2'd2, 22, 1'b0, 1};
    vecs[4] = '{2'd0, 6,  1'b1, 0};
    vecs[5] = '{2'd3, 34, 1'b0, 1};
    vecs[6] = '{2'd0, 0,  1'b0, 0};

    reset = 1'b1; start = 1'b0; mode = '0; len_words = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {squeeze, pack, dout_valid, dout_last, busy, done, err}, 0);
    chk("reset_dout", dout, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++)
      run_session(vecs[i].mode, vecs[i].len, vecs[i].stall, vecs[i].exp_sq, 64'(i) << 16);

    // Permutation never completes: timeout after first block
    core_hang = 1'b1;
    d0 = done_cnt; sq0 = sq_cnt;
    begin_session(2'd1, 12, 64'h77_0000, 9);
    wait_done(d0, 500);
    chk("tmo_delay", done_cyc - sq_cyc, PT);
    chk("tmo_err", err, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_xfers", xfers - sess_x0, 9);
    chk("tmo_squeezes", sq_cnt - sq0, 1);
    chk("tmo_no_more_words", q.size(), 0);
    repeat (10) @(negedge clk);
    chk("tmo_err_sticky", err, 1);
    core_hang = 1'b0;
    run_session(2'd1, 1, 1'b0, 0, 64'h88_0000);

    // Reset while waiting for a permutation
    core_hang = 1'b1;
    d0 = done_cnt; sq0 = sq_cnt;
    begin_session(2'd1, 10, 64'h99_0000, 9);
    for (int c = 0; c < 200 && sq_cnt == sq0; c++) @(negedge clk);
    chk("rst_squeeze_seen", sq_cnt - sq0, 1);
    repeat (5) @(negedge clk);
    reset = 1'b1; #1;
    chk("rst_mid_ctrl", {squeeze, pack, dout_valid, dout_last, busy, done, err}, 0);
    chk("rst_mid_dout", dout, 0);
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    core_hang = 1'b0;
    run_session(2'd1, 1, 1'b0, 0, 64'hAA_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
